uart_tx_engine: RTL and testbench
=================================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 The block SHALL have no parameters; FIFO depth is fixed at 16 entries of 8 bits.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 fifoWritePointer  input  5  writer-side pointer: bits [3:0] are the address, bit 4 is the wrap flag.
REQ-005 fifoReadData  input  8  asynchronous read data from the 16x8 FIFO memory at readAddress.
REQ-006 readAddress  output  4  equals readPointer[3:0].
REQ-007 readPointer  output  5  read pointer with wrap flag, exported so the writer side can compute full.
REQ-008 baudDivisor  input  16  bit period is baudDivisor+1 clocks.
REQ-009 dataBits  input  2  character length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-010 parityEnable  input  1  when 1, a parity bit is inserted after the data bits.
REQ-011 parityOdd  input  1  1=odd parity, 0=even parity.
REQ-012 twoStopBits  input  1  1=two stop bits, 0=one stop bit.
REQ-013 txd  output  1  serial line; idles high.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 txEmpty  output  1  high when the FIFO is empty and the state is IDLE.

Function
REQ-016 FIFO empty SHALL be defined as fifoWritePointer == readPointer, compared over all 5 bits.
REQ-017 The state machine SHALL use the states IDLE, START, DATA, PARITY, STOP1 and STOP2.
REQ-018 IDLE with FIFO not empty SHALL, in one cycle:
- latch fifoReadData into the shift register;
- latch dataBits, parityEnable, parityOdd, twoStopBits and baudDivisor;
- increment readPointer modulo 32;
- move to START.
REQ-019 txd SHALL be 0 in START, the shift-register LSB in DATA, the parity bit in PARITY, and 1 in IDLE, STOP1 and STOP2.
REQ-020 Each of START, DATA-bit, PARITY, STOP1 and STOP2 SHALL last exactly latchedDivisor+1 clocks, timed by a down-counter reloaded on every bit boundary.
REQ-021 DATA SHALL shift the register right once per bit and SHALL exit after 5 to 8 bits, as set by the latched dataBits.
REQ-022 DATA SHALL go to PARITY if parity is enabled, otherwise to STOP1.
REQ-023 STOP1 SHALL go to STOP2 if twoStopBits is set, otherwise to IDLE.
REQ-024 The parity bit SHALL be the XOR of the transmitted data bits only, inverted when parityOdd is 1.
REQ-025 Back-to-back characters: when the final stop bit ends and the FIFO is not empty, the block SHALL pass through IDLE for exactly one clock and then load the next byte, giving one idle-high clock between frames.
REQ-026 txd SHALL fall exactly one clock after the load edge, i.e. 2 clocks after fifoWritePointer changes a previously empty FIFO.
REQ-027 readPointer wrap from 31 to 0 SHALL be seamless, and the empty test SHALL stay correct across the wrap.
REQ-028 Input changes to baudDivisor, dataBits or the parity/stop controls mid-frame SHALL have no effect until the next load.
REQ-029 A fifoWritePointer change in the same cycle as a load SHALL NOT affect the byte loaded; the byte comes from the pre-edge readAddress.
REQ-030 baudDivisor = 0 SHALL be legal and SHALL give one clock per bit.
REQ-031 txd, busy and txEmpty SHALL be registered outputs.

Reset
REQ-032 On reset: state=IDLE, readPointer=0, txd=1, busy=0, shift register=0, counters=0.
REQ-033 txEmpty after reset SHALL follow REQ-015, i.e. txEmpty=1 when fifoWritePointer=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame and drive txd=1 on the next edge.
REQ-035 A byte whose load cycle completed before an aborting reset SHALL be discarded; readPointer returns to 0.

Verification
REQ-036 Single byte: baudDivisor=3, 8N1, write 0x55 -> txd sequence 0,1,0,1,0,1,0,1,0,1 (LSB first), each bit 4 clocks, then idle; readPointer=1.
REQ-037 Parity and two stop bits: 7E2 with 0x41 -> seven bits 1,0,0,0,0,0,1, parity 0, stop 1,1; 7O2 with the same byte -> parity 1.
REQ-038 Wrap: stream 40 bytes with the writer running ahead -> every byte is transmitted in order; readPointer passes 31->0 without error; txEmpty=1 at the end.
REQ-039 Back-to-back: 16 bytes preloaded, baudDivisor=0 -> each 8N1 frame is 10 clocks plus 1 idle clock (11 clocks per frame); busy is low only during the idle clocks.
REQ-040 Reset mid-frame: assert reset during DATA bit 3 -> txd=1, busy=0, readPointer=0 on the next edge; the next frame starts cleanly.
REQ-041 Config change: change dataBits from 11 to 00 during frame A -> frame A keeps 8 bits; frame B uses 5 bits.

Source files
------------

// File: rtl/uart_tx_engine_if.sv
// FIFO-side connection of the UART transmitter: writer pointer and read data in,
// read address and read pointer (with wrap flag) back to the writer side.
interface uart_tx_engine_if;
  logic [4:0] fifoWritePointer;
  logic [7:0] fifoReadData;
  logic [3:0] readAddress;
  logic [4:0] readPointer;

  modport master (
    output fifoWritePointer,
    output fifoReadData,
    input  readAddress,
    input  readPointer
  );

  modport slave (
    input  fifoWritePointer,
    input  fifoReadData,
    output readAddress,
    output readPointer
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine draining a 16x8 FIFO: 5-8 data bits, optional parity,
// one or two stop bits, bit period of baudDivisor+1 clocks.
//
// state  | meaning
// IDLE   | line high, waiting for a non-empty FIFO; loads byte and config
// START  | start bit (low)
// DATA   | data bits, LSB first, shift register moves right per bit
// PARITY | parity bit over the transmitted data bits
// STOP1  | first stop bit (high)
// STOP2  | optional second stop bit (high)
module uart_tx_engine (
  input  logic                   clock,
  input  logic                   reset,
  uart_tx_engine_if.slave        fifo,
  input  logic [15:0]            baudDivisor,
  input  logic [1:0]             dataBits,
  input  logic                   parityEnable,
  input  logic                   parityOdd,
  input  logic                   twoStopBits,
  output logic                   txd,
  output logic                   busy,
  output logic                   txEmpty
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t      state;
  logic [4:0]  read_ptr;
  logic [7:0]  shift_reg;
  logic [15:0] bit_timer;
  logic [15:0] div_q;
  logic [2:0]  bit_idx;
  logic [2:0]  last_bit;
  logic        parity_en_q;
  logic        two_stop_q;
  logic        parity_bit;

  logic        fifo_empty;
  logic        bit_done;
  logic [7:0]  data_mask;
  logic        load_parity;
  logic        tx_level;

  assign fifo.readPointer = read_ptr;
  assign fifo.readAddress = read_ptr[3:0];
  assign fifo_empty       = (fifo.fifoWritePointer == read_ptr);
  assign bit_done         = (bit_timer == 16'd0);

  // Parity is fixed at load time from the bits that will actually be sent.
  always_comb begin
    data_mask = 8'hFF;
    case (dataBits)
      2'd0:    data_mask = 8'h1F;
      2'd1:    data_mask = 8'h3F;
      2'd2:    data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
    load_parity = (^(fifo.fifoReadData & data_mask)) ^ parityOdd;
  end

  always_comb begin
    tx_level = 1'b1;
    case (state)
      START:   tx_level = 1'b0;
      DATA:    tx_level = shift_reg[0];
      PARITY:  tx_level = parity_bit;
      default: tx_level = 1'b1;
    endcase
  end

  // Outputs are registered from the current state, so the line lags the state by
  // one clock: txd falls one clock after the load edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      read_ptr    <= 5'd0;
      shift_reg   <= 8'd0;
      bit_timer   <= 16'd0;
      div_q       <= 16'd0;
      bit_idx     <= 3'd0;
      last_bit    <= 3'd0;
      parity_en_q <= 1'b0;
      two_stop_q  <= 1'b0;
      parity_bit  <= 1'b0;
      txd         <= 1'b1;
      busy        <= 1'b0;
      txEmpty     <= (fifo.fifoWritePointer == 5'd0);
    end else begin
      txd     <= tx_level;
      busy    <= (state != IDLE);
      txEmpty <= (state == IDLE) && fifo_empty;

      if (state != IDLE)
        bit_timer <= bit_done ? div_q : bit_timer - 16'd1;

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shift_reg   <= fifo.fifoReadData;
            last_bit    <= {1'b1, dataBits};
            parity_en_q <= parityEnable;
            two_stop_q  <= twoStopBits;
            parity_bit  <= load_parity;
            div_q       <= baudDivisor;
            bit_timer   <= baudDivisor;
            bit_idx     <= 3'd0;
            read_ptr    <= read_ptr + 5'd1;
            state       <= START;
          end
        end
        START: begin
          if (bit_done) state <= DATA;
        end
        DATA: begin
          if (bit_done) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == last_bit)
              state <= parity_en_q ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (bit_done) state <= STOP1;
        end
        STOP1: begin
          if (bit_done) state <= two_stop_q ? STOP2 : IDLE;
        end
        STOP2: begin
          if (bit_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: a frame-level model predicts the line waveform and
// status outputs every cycle; directed and randomized traffic drive the FIFO side.
module tb_uart_tx_engine;

  typedef int iq_t[$];

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] baudDivisor;
  logic [1:0]  dataBits;
  logic        parityEnable;
  logic        parityOdd;
  logic        twoStopBits;
  logic        txd;
  logic        busy;
  logic        txEmpty;

  logic [7:0]  mem [16];
  logic [4:0]  wp;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  uart_tx_engine_if fif ();
  assign fif.fifoWritePointer = wp;
  assign fif.fifoReadData     = mem[fif.readAddress];

  uart_tx_engine dut (
    .clock        (clock),
    .reset        (reset),
    .fifo         (fif),
    .baudDivisor  (baudDivisor),
    .dataBits     (dataBits),
    .parityEnable (parityEnable),
    .parityOdd    (parityOdd),
    .twoStopBits  (twoStopBits),
    .txd          (txd),
    .busy         (busy),
    .txEmpty      (txEmpty)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-clock line levels of one whole frame, start bit through last stop bit.
  function automatic iq_t frame_wave(input logic [7:0] b, input int nb, input bit pe,
                                     input bit po, input bit two, input int div);
    iq_t bits;
    iq_t w;
    bit par;
    par = po;
    bits.push_back(0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(int'(b[i]));
      par ^= b[i];
    end
    if (pe) bits.push_back(int'(par));
    bits.push_back(1);
    if (two) bits.push_back(1);
    foreach (bits[k])
      for (int r = 0; r <= div; r++) w.push_back(bits[k]);
    return w;
  endfunction

  // Model: the engine is either idle or playing out a queued frame waveform.
  iq_t        m_q;
  logic [4:0] m_rp = 5'd0;
  int         m_txd, m_busy, m_empty;
  bit         started = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_q.delete();
      m_rp    = 5'd0;
      m_txd   = 1;
      m_busy  = 0;
      m_empty = (wp == 5'd0) ? 1 : 0;
      started = 1'b1;
    end else if (m_q.size() > 0) begin
      m_txd   = m_q.pop_front();
      m_busy  = 1;
      m_empty = 0;
    end else begin
      m_txd   = 1;
      m_busy  = 0;
      m_empty = (wp == m_rp) ? 1 : 0;
      if (wp != m_rp) begin
        m_q  = frame_wave(mem[m_rp[3:0]], int'(dataBits) + 5, parityEnable, parityOdd,
                          twoStopBits, int'(baudDivisor));
        m_rp = m_rp + 5'd1;
      end
    end
    #1;
    if (started) begin
      check("txd", int'(txd), m_txd);
      check("busy", int'(busy), m_busy);
      check("txEmpty", int'(txEmpty), m_empty);
      check("readPointer", int'(fif.readPointer), int'(m_rp));
      check("readAddress", int'(fif.readAddress), int'(m_rp[3:0]));
    end
  end

  task automatic write_byte(input logic [7:0] b);
    mem[wp[3:0]] = b;
    wp = wp + 5'd1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(m_q.size() == 0 && wp == m_rp) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("idle_within_budget", (n < budget) ? 1 : 0, 1);
    @(negedge clock);
    @(negedge clock);
  endtask

  initial begin
    iq_t        w;
    int         written;
    int         guard;
    logic [4:0] fill;

    reset        = 1'b1;
    wp           = 5'd0;
    baudDivisor  = 16'd0;
    dataBits     = 2'd3;
    parityEnable = 1'b0;
    parityOdd    = 1'b0;
    twoStopBits  = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    repeat (3) @(negedge clock);
    check("reset_txd", int'(txd), 1);
    check("reset_txEmpty", int'(txEmpty), 1);
    reset = 1'b0;

    // Pin the model against hand-computed frames.
    w = frame_wave(8'h55, 8, 1'b0, 1'b0, 1'b0, 3);
    check("model_8n1_len", w.size(), 40);
    check("model_8n1_start", w[0], 0);
    check("model_8n1_d0", w[4], 1);
    check("model_8n1_d7", w[32], 0);
    check("model_8n1_stop", w[39], 1);
    w = frame_wave(8'h41, 7, 1'b1, 1'b0, 1'b1, 0);
    check("model_7e2_len", w.size(), 11);
    check("model_7e2_parity", w[8], 0);
    w = frame_wave(8'h41, 7, 1'b1, 1'b1, 1'b1, 0);
    check("model_7o2_parity", w[8], 1);

    // Single byte 0x55, 8N1, four clocks per bit.
    @(negedge clock);
    baudDivisor = 16'd3;
    write_byte(8'h55);
    @(posedge clock); #1;
    check("txd_high_at_load", int'(txd), 1);
    @(posedge clock); #1;
    check("txd_fall_latency", int'(txd), 0);
    wait_idle(200);
    check("rp_after_single", int'(fif.readPointer), 1);

    // 7E2 then 7O2 with 0x41.
    baudDivisor  = 16'd1;
    dataBits     = 2'd2;
    parityEnable = 1'b1;
    parityOdd    = 1'b0;
    twoStopBits  = 1'b1;
    write_byte(8'h41);
    wait_idle(200);
    parityOdd = 1'b1;
    write_byte(8'h41);
    wait_idle(200);

    // Config change mid-frame: A keeps 8 bits, B uses 5.
    dataBits     = 2'd3;
    parityEnable = 1'b0;
    twoStopBits  = 1'b0;
    write_byte(8'hC3);
    write_byte(8'h5A);
    repeat (6) @(negedge clock);
    dataBits    = 2'd0;
    baudDivisor = 16'd2;
    wait_idle(400);

    // Back-to-back: 16 preloaded bytes, one clock per bit, 11 clocks per frame.
    baudDivisor = 16'd0;
    dataBits    = 2'd3;
    for (int i = 0; i < 16; i++) write_byte(8'($urandom_range(0, 255)));
    repeat (176) @(posedge clock);
    #1;
    check("b2b_busy_last_stop", int'(busy), 1);
    @(posedge clock); #1;
    check("b2b_busy_end", int'(busy), 0);
    check("b2b_txEmpty_end", int'(txEmpty), 1);
    wait_idle(50);

    // Reset during data bit 3.
    @(negedge clock);
    baudDivisor = 16'd2;
    write_byte(8'hA5);
    repeat (14) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    wp    = 5'd0;
    @(posedge clock); #1;
    check("abort_txd", int'(txd), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_rp", int'(fif.readPointer), 0);
    @(negedge clock);
    reset = 1'b0;
    write_byte(8'h3C);
    wait_idle(200);
    check("rp_after_abort", int'(fif.readPointer), 1);

    // Randomized stream of 40 bytes across the pointer wrap.
    written = 0;
    guard   = 0;
    while (written < 40 && guard < 20000) begin
      @(negedge clock);
      guard++;
      if ($urandom_range(0, 7) == 0) begin
        baudDivisor  = 16'($urandom_range(0, 2));
        dataBits     = 2'($urandom_range(0, 3));
        parityEnable = 1'($urandom_range(0, 1));
        parityOdd    = 1'($urandom_range(0, 1));
        twoStopBits  = 1'($urandom_range(0, 1));
      end
      fill = wp - m_rp;
      if (fill < 5'd16 && $urandom_range(0, 3) == 0) begin
        write_byte(8'($urandom_range(0, 255)));
        written++;
      end
    end
    check("stream_written", written, 40);
    wait_idle(5000);
    check("stream_txEmpty", int'(txEmpty), 1);
    check("stream_rp", int'(fif.readPointer), int'(wp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
